// File: rtl/seven_seg_pkg.sv
// Shared constants and the code-to-segment mapping for the 7-segment display
// driver. Segment vectors are active-high internally, bit0=a ... bit6=g.
package seven_seg_pkg;

  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_E     = 7'b1111001;

  // Map a 4-bit code to its segment pattern; codes 10..15 show a dash.
  function automatic logic [6:0] bcd_to_seg(input logic [BCD_W-1:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = 7'b0111111;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_decode.sv
// Combinational BCD-to-segment decoder. Error and blanking are resolved by
// the parent; this block only knows digits and the dash for codes 10..15.
module bcd_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [BCD_W-1:0] code,
  output logic [6:0]       seg
);

  assign seg = bcd_to_seg(code);

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit 7-segment driver with frame-synchronous loading,
// leading-zero blanking, blink and an error display mode. All pin outputs
// are registered so anode and segments change together (no ghosting).
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter int BLINK_FRAMES   = 64,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [BCD_W*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]       dp_i,
  input  logic                        load_i,
  input  logic                        err_i,
  input  logic                        blank_lz_i,
  input  logic                        blink_i,
  output logic [6:0]                  seg_o,
  output logic                        dp_o,
  output logic [NUM_DIGITS-1:0]       an_o,
  output logic                        frame_o
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(BLINK_FRAMES - 1);

  // Pin-level "off" values; XOR with these applies the polarity.
  localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
  localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ?
                                              {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [CNT_W-1:0]                cnt;
  logic [IDX_W-1:0]                idx;
  logic [FC_W-1:0]                 fcnt;
  logic                            phase;
  logic [BCD_W*NUM_DIGITS-1:0]     shadow_dig, pend_dig;
  logic [NUM_DIGITS-1:0]           shadow_dp, pend_dp;
  logic                            pending;
  logic                            tick, wrap;

  logic [NUM_DIGITS-1:0]           lz_mask;
  logic                            zero_run;
  logic [BCD_W-1:0]                cur_code;
  logic [6:0]                      dec_seg;
  logic [6:0]                      seg_n;
  logic                            dp_n;
  logic [NUM_DIGITS-1:0]           an_n;

  assign tick = (cnt == CNT_MAX);
  assign wrap = tick && (idx == IDX_LAST);

  // Prescaler, digit index and the frame pulse (high while idx is freshly 0).
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      idx     <= '0;
      frame_o <= 1'b0;
    end else begin
      cnt     <= tick ? '0 : cnt + 1'b1;
      frame_o <= wrap;
      if (tick) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  // Pending/shadow pair: shadow only changes on the wrap so a frame never tears.
  // NOTE: these are plain registers, not a memory array, so they are reset
  // to give a defined all-zero display straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_dig   <= '0;
      pend_dp    <= '0;
      pending    <= 1'b0;
      shadow_dig <= '0;
      shadow_dp  <= '0;
    end else begin
      if (load_i) begin
        pend_dig <= digits_i;
        pend_dp  <= dp_i;
      end
      if (wrap) begin
        if (pending) begin
          shadow_dig <= pend_dig;
          shadow_dp  <= pend_dp;
        end
        pending <= load_i;
      end else if (load_i) begin
        pending <= 1'b1;
      end
    end
  end

  // Blink frame counter and phase; free-running regardless of blink_i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt  <= '0;
      phase <= 1'b0;
    end else if (wrap) begin
      if (fcnt == FC_MAX) begin
        fcnt  <= '0;
        phase <= ~phase;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  // Leading-zero mask: bit k set when shadow digits NUM_DIGITS-1..k are all 0.
  // NOTE: every variable gets a default before any conditional logic so the
  // combinational blocks cannot infer latches.
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run   = zero_run && (shadow_dig[k*BCD_W +: BCD_W] == '0);
      lz_mask[k] = zero_run;
    end
  end

  assign cur_code = shadow_dig[idx*BCD_W +: BCD_W];

  bcd_seg_decode u_decode (
    .code (cur_code),
    .seg  (dec_seg)
  );

  // Next pin values for the active digit: error beats blanking, blink gates anodes.
  always_comb begin
    seg_n       = dec_seg;
    dp_n        = shadow_dp[idx];
    an_n        = '0;
    an_n[idx]   = 1'b1;
    if (err_i) begin
      seg_n = SEG_E;
      dp_n  = 1'b0;
    end else if (blank_lz_i && lz_mask[idx]) begin
      seg_n = SEG_BLANK;
      dp_n  = 1'b0;
    end
    if (blink_i && phase) an_n = '0;
  end

  // Output register with polarity applied; anode and segments move together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_o <= SEG_OFF;
      dp_o  <= DP_OFF;
      an_o  <= AN_OFF;
    end else begin
      seg_o <= seg_n ^ SEG_OFF;
      dp_o  <= dp_n ^ DP_OFF;
      an_o  <= an_n ^ AN_OFF;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with NUM_DIGITS=4, CLK_DIV=4,
// BLINK_FRAMES=2, active-high segments and active-low anodes.
module tb_seven_seg_scanner;

  localparam logic [6:0] S0   = 7'b0111111;
  localparam logic [6:0] S1   = 7'b0000110;
  localparam logic [6:0] S2   = 7'b1011011;
  localparam logic [6:0] S3   = 7'b1001111;
  localparam logic [6:0] S4   = 7'b1100110;
  localparam logic [6:0] S5   = 7'b1101101;
  localparam logic [6:0] S6   = 7'b1111101;
  localparam logic [6:0] S7   = 7'b0000111;
  localparam logic [6:0] S8   = 7'b1111111;
  localparam logic [6:0] SBL  = 7'b0000000;
  localparam logic [6:0] SDSH = 7'b1000000;
  localparam logic [6:0] SE   = 7'b1111001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits_i;
  logic [3:0]  dp_i;
  logic        load_i, err_i, blank_lz_i, blink_i;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  an_o;
  logic        frame_o;

  int n_vec = 0;
  int n_err = 0;
  int n;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .NUM_DIGITS     (4),
    .CLK_DIV        (4),
    .BLINK_FRAMES   (2),
    .SEG_ACTIVE_LOW (0),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits_i   (digits_i),
    .dp_i       (dp_i),
    .load_i     (load_i),
    .err_i      (err_i),
    .blank_lz_i (blank_lz_i),
    .blink_i    (blink_i),
    .seg_o      (seg_o),
    .dp_o       (dp_o),
    .an_o       (an_o),
    .frame_o    (frame_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance to the negedge right after the next frame_o pulse; returns cycles taken.
  task automatic wait_frame(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (frame_o !== 1'b1 && cycles < 64);
    if (frame_o !== 1'b1) check("frame_timeout", 32'(frame_o), 32'd1);
  endtask

  task automatic pulse_load(input logic [15:0] d, input logic [3:0] dp);
    digits_i = d;
    dp_i     = dp;
    load_i   = 1'b1;
    @(negedge clk);
    load_i   = 1'b0;
  endtask

  // Called just after a frame pulse; samples each digit mid-slot.
  task automatic scan_check(input string tag, input logic [27:0] segs, input logic [3:0] dps);
    logic [3:0] an_exp;
    for (int k = 0; k < 4; k++) begin
      repeat ((k == 0) ? 2 : 4) @(negedge clk);
      an_exp    = 4'b1111;
      an_exp[k] = 1'b0;
      check($sformatf("%s_seg%0d", tag, k), 32'(seg_o), 32'(segs[k*7 +: 7]));
      check($sformatf("%s_an%0d", tag, k), 32'(an_o), 32'(an_exp));
      check($sformatf("%s_dp%0d", tag, k), 32'(dp_o), 32'(dps[k]));
    end
  endtask

  // One frame of blink observation: first and last digit slots.
  task automatic blink_frame(input string tag, input logic on);
    int c;
    wait_frame(c);
    repeat (2) @(negedge clk);
    check({tag, "_d0"}, 32'(an_o), on ? 32'b1110 : 32'b1111);
    repeat (12) @(negedge clk);
    check({tag, "_d3"}, 32'(an_o), on ? 32'b0111 : 32'b1111);
  endtask

  initial begin
    rst_n = 1'b0; digits_i = '0; dp_i = '0; load_i = 1'b0;
    err_i = 1'b0; blank_lz_i = 1'b0; blink_i = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_seg", 32'(seg_o), 32'b0000000);
    check("rst_an", 32'(an_o), 32'b1111);
    check("rst_dp", 32'(dp_o), 32'd0);
    check("rst_frame", 32'(frame_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_seg", 32'(seg_o), 32'(S0));
    check("post_rst_an", 32'(an_o), 32'b1110);

    // Frame period and basic scan
    wait_frame(n);
    wait_frame(n);
    check("frame_period", 32'(n), 32'd16);
    pulse_load(16'h1234, 4'b0010);
    wait_frame(n);
    scan_check("scan_1234", {S1, S2, S3, S4}, 4'b0010);

    // Tear-free load issued while idx=2
    wait_frame(n);
    repeat (8) @(negedge clk);
    pulse_load(16'h5678, 4'b0000);
    @(negedge clk);
    check("tear_seg2", 32'(seg_o), 32'(S2));
    check("tear_an2", 32'(an_o), 32'b1011);
    repeat (4) @(negedge clk);
    check("tear_seg3", 32'(seg_o), 32'(S1));
    check("tear_an3", 32'(an_o), 32'b0111);
    wait_frame(n);
    scan_check("scan_5678", {S5, S6, S7, S8}, 4'b0000);

    // Leading-zero blanking
    blank_lz_i = 1'b1;
    wait_frame(n);
    pulse_load(16'h0040, 4'b1111);
    wait_frame(n);
    scan_check("lz_0040", {SBL, SBL, S4, S0}, 4'b0011);

    // Error mode overrides blanking, immediate effect
    err_i = 1'b1;
    @(negedge clk);
    check("err_fast_seg", 32'(seg_o), 32'(SE));
    check("err_fast_dp", 32'(dp_o), 32'd0);
    wait_frame(n);
    scan_check("err", {SE, SE, SE, SE}, 4'b0000);

    // Code 10+ shows a dash
    err_i = 1'b0;
    blank_lz_i = 1'b0;
    wait_frame(n);
    pulse_load(16'h00B0, 4'b0000);
    wait_frame(n);
    scan_check("dash", {S0, S0, SDSH, S0}, 4'b0000);

    // Mid-scan asynchronous reset, then blink from a known phase
    blink_i = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_seg", 32'(seg_o), 32'b0000000);
    check("midrst_an", 32'(an_o), 32'b1111);
    check("midrst_dp", 32'(dp_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_rel_seg", 32'(seg_o), 32'(S0));
    check("midrst_rel_an", 32'(an_o), 32'b1110);
    blink_frame("blink_f1", 1'b1);
    blink_frame("blink_f2", 1'b0);
    blink_frame("blink_f3", 1'b0);
    blink_frame("blink_f4", 1'b1);
    blink_frame("blink_f5", 1'b1);
    blink_frame("blink_f6", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Parametrised, time-multiplexed driver for an N-digit common-anode/cathode 7-segment display.
- Successor to the single-digit BCD-to-7-segment decoder. Adds multi-digit scanning, tear-free frame-synchronous loading, leading-zero blanking, blink, and a per-display error mode.
- Sits between the datapath (packed BCD result plus error flag) and the board display pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; range 2..8.
- CLK_DIV, 50000: clk cycles per digit slot; minimum 2.
- BLINK_FRAMES, 64: full scan frames per blink half-period; minimum 1.
- SEG_ACTIVE_LOW, 0: 1 inverts seg_o and dp_o at the pins.
- AN_ACTIVE_LOW, 1: 1 makes an_o active-low.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- digits_i  in  4*NUM_DIGITS  packed BCD; [3:0] is digit 0 (least significant).
- dp_i  in  NUM_DIGITS  decimal-point enables, bit k belongs to digit k.
- load_i  in  1  request to capture digits_i/dp_i.
- err_i  in  1  error display mode (level).
- blank_lz_i  in  1  leading-zero blanking enable.
- blink_i  in  1  blink enable.
- seg_o  out  7  segments; bit0=a … bit6=g.
- dp_o  out  1  decimal point.
- an_o  out  NUM_DIGITS  digit enables, one-hot (or all-off).
- frame_o  out  1  one-cycle pulse when the digit index wraps to 0.

Behaviour:
- Reset (async assert, sync-safe release):
  - prescaler=0, idx=0, frame counter=0, blink phase=0.
  - shadow digits=0, shadow dp=0, pending=0.
  - seg_o=all off, dp_o=off, an_o=all off, frame_o=0. "Off" means pin level after the polarity parameters are applied.
- Prescaler:
  - Counts 0..CLK_DIV-1; tick when count=CLK_DIV-1.
  - On tick: idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1.
  - frame_o=1 in the cycle idx changes to 0.
- Load:
  - load_i=1 captures digits_i/dp_i into a pending register and sets pending.
  - Pending transfers to shadow in the same cycle as the wrap to idx=0, so the displayed frame never tears.
  - A second load before the wrap overwrites pending; the last value wins.
  - load_i on the wrap cycle itself: the new value goes to pending, and shadow takes the previous pending value (if any).
- Decode (per active digit d = shadow[idx]; internal segment convention is active-high):
  - 0..9 use the standard pattern: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111 (shown g..a).
  - 10..15 display a dash, 1000000.
- Error mode:
  - While err_i=1, every digit shows "E" = 1111001 (a,d,e,f,g on; b,c off) and dp is off.
  - err_i overrides blanking, but blink still applies.
  - Takes effect without waiting for a frame boundary.
- Leading-zero blanking (blank_lz_i=1, err_i=0):
  - Digit k is blanked (segments and dp off) if shadow digits NUM_DIGITS-1 down to k are all 0.
  - Digit 0 is never blanked.
- Blink:
  - The frame counter increments on frame_o; on reaching BLINK_FRAMES-1 it clears and blink phase toggles.
  - While blink_i=1 and phase=1, an_o is all off; scanning continues.
  - blink_i=0 does not reset the phase.
- Outputs:
  - seg_o, dp_o and an_o are registered: one-cycle latency from idx/shadow/mode changes.
  - an_o is one-hot at idx; the enabled digit and its segments always update together.
- Boundary: when idx advances, both the segment pattern and the anode change in the same registered cycle, so there is no ghosting between digits.

Decomposition:
- Shared package seven_seg_pkg:
  - segment constants SEG_BLANK, SEG_DASH, SEG_E;
  - a function mapping a 4-bit code to its 7-bit segment pattern;
  - constant BCD_W=4.
- One sub-module: bcd_seg_decode (combinational code→segments including the dash; error and blank handled in the parent).

Test Plan (NUM_DIGITS=4, CLK_DIV=4, BLINK_FRAMES=2, SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=1):
- Reset: hold rst_n=0 mid-scan → seg_o=0000000 and an_o=1111 immediately; after release, the first an_o is 1110 with seg_o=0111111 (0).
- Scan: load digits_i=16'h1234 → after the next frame_o, the bench observes an_o 1110/1101/1011/0111 with seg_o 1100110/1001111/1011011/0000110, each held 4 cycles.
- Tear-free load: load 16'h5678 while idx=2 → digits 2,3 still show 2,1 in this frame; the new value shows from the next idx=0.
- LZ blanking: blank_lz_i=1 with 16'h0040 → digits 3 and 2 show 0000000 with anodes active; digit 1 shows 4, digit 0 shows 0.
- Error and code 10+: err_i=1 → all digits 1111001 with dp_o=0 within 1 cycle; err_i=0 with digit code 4'hB → 1000000.
- Blink: blink_i=1 → an_o is 1111 for 2 frames, then scans for 2 frames, repeating.
